// File: rtl/imu_spi_responder.sv
// SPI mode-3 target emulating the IMU register interface: WHO_AM_I, four ctrl
// registers and 12 sensor bytes from a snapshot of sample_data, auto-increment.
module imu_spi_responder #(
  parameter logic [7:0] WHO_AM_I_VAL = 8'h6A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SPC,
  input  logic        CS,
  input  logic        SDI,
  output logic        SDO,
  input  logic [95:0] sample_data,
  output logic [7:0]  ctrl1_xl,
  output logic [7:0]  ctrl2_g,
  output logic [7:0]  ctrl4_c,
  output logic [7:0]  ctrl9_xl,
  output logic        wr_valid,
  output logic [6:0]  wr_addr,
  output logic [7:0]  wr_data
);

  localparam int unsigned SAMPLE_W = 96;
  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned CNT_W    = 3;

  typedef enum logic [2:0] {WAIT_CS_HIGH, IDLE, ADDR, RD, WR} state_t;

  logic [1:0] spc_sync, cs_sync, sdi_sync;
  logic       spc_q, cs_q;
  logic       spc_s, cs_s, sdi_s;
  logic       spc_rise, spc_fall, cs_rise, cs_fall;

  state_t              state, state_n;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [BYTE_W-1:0]   shreg, shreg_n, rx_byte;
  logic [ADDR_W-1:0]   addr, addr_n, addr_inc;
  logic [SAMPLE_W-1:0] snap, snap_n;
  logic                sdo_n, wr_valid_n;
  logic [ADDR_W-1:0]   wr_addr_n;
  logic [BYTE_W-1:0]   wr_data_n;
  logic [BYTE_W-1:0]   ctrl1_n, ctrl2_n, ctrl4_n, ctrl9_n;

  // CS synchroniser resets low so a transaction live across reset stays parked
  always_ff @(posedge clk) begin
    if (reset) begin
      spc_sync <= 2'b11;
      cs_sync  <= 2'b00;
      sdi_sync <= 2'b00;
      spc_q    <= 1'b1;
      cs_q     <= 1'b0;
    end else begin
      spc_sync <= {spc_sync[0], SPC};
      cs_sync  <= {cs_sync[0], CS};
      sdi_sync <= {sdi_sync[0], SDI};
      spc_q    <= spc_sync[1];
      cs_q     <= cs_sync[1];
    end
  end

  assign spc_s    = spc_sync[1];
  assign cs_s     = cs_sync[1];
  assign sdi_s    = sdi_sync[1];
  assign spc_rise = spc_s & ~spc_q;
  assign spc_fall = ~spc_s & spc_q;
  assign cs_rise  = cs_s & ~cs_q;
  assign cs_fall  = ~cs_s & cs_q;
  assign rx_byte  = {shreg[BYTE_W-2:0], sdi_s};
  assign addr_inc = ADDR_W'(addr + ADDR_W'(1));

  // Read map; ctrl is {ctrl1, ctrl2, ctrl4, ctrl9}
  function automatic logic [7:0] reg_rd(input logic [6:0] a, input logic [95:0] s,
                                        input logic [31:0] ctrl);
    case (a)
      7'h0F:   reg_rd = WHO_AM_I_VAL;
      7'h10:   reg_rd = ctrl[31:24];
      7'h11:   reg_rd = ctrl[23:16];
      7'h13:   reg_rd = ctrl[15:8];
      7'h18:   reg_rd = ctrl[7:0];
      7'h22:   reg_rd = s[87:80];
      7'h23:   reg_rd = s[95:88];
      7'h24:   reg_rd = s[71:64];
      7'h25:   reg_rd = s[79:72];
      7'h26:   reg_rd = s[55:48];
      7'h27:   reg_rd = s[63:56];
      7'h28:   reg_rd = s[39:32];
      7'h29:   reg_rd = s[47:40];
      7'h2A:   reg_rd = s[23:16];
      7'h2B:   reg_rd = s[31:24];
      7'h2C:   reg_rd = s[7:0];
      7'h2D:   reg_rd = s[15:8];
      default: reg_rd = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WAIT_CS_HIGH;
      bit_cnt  <= '0;
      shreg    <= '0;
      addr     <= '0;
      snap     <= '0;
      SDO      <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      ctrl1_xl <= 8'h00;
      ctrl2_g  <= 8'h00;
      ctrl4_c  <= 8'h00;
      ctrl9_xl <= 8'hE0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      addr     <= addr_n;
      snap     <= snap_n;
      SDO      <= sdo_n;
      wr_valid <= wr_valid_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      ctrl1_xl <= ctrl1_n;
      ctrl2_g  <= ctrl2_n;
      ctrl4_c  <= ctrl4_n;
      ctrl9_xl <= ctrl9_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    addr_n     = addr;
    snap_n     = snap;
    sdo_n      = SDO;
    wr_valid_n = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    ctrl1_n    = ctrl1_xl;
    ctrl2_n    = ctrl2_g;
    ctrl4_n    = ctrl4_c;
    ctrl9_n    = ctrl9_xl;

    // CS rise aborts any active transfer, dropping a partial byte
    if (cs_rise && (state == ADDR || state == RD || state == WR)) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      sdo_n     = 1'b0;
    end else begin
      case (state)
        WAIT_CS_HIGH: begin
          sdo_n = 1'b0;
          if (cs_s) state_n = IDLE;
        end
        IDLE: begin
          sdo_n = 1'b0;
          if (cs_fall) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            snap_n    = sample_data;
          end
        end
        ADDR: begin
          if (spc_rise) begin
            shreg_n   = rx_byte;
            bit_cnt_n = CNT_W'(bit_cnt + CNT_W'(1));
            if (bit_cnt == CNT_W'(7)) begin
              addr_n    = rx_byte[ADDR_W-1:0];
              bit_cnt_n = '0;
              if (rx_byte[BYTE_W-1]) begin
                state_n = RD;
                shreg_n = reg_rd(rx_byte[ADDR_W-1:0], snap,
                                 {ctrl1_xl, ctrl2_g, ctrl4_c, ctrl9_xl});
              end else begin
                state_n = WR;
              end
            end
          end
        end
        RD: begin
          if (spc_fall) begin
            sdo_n     = shreg[BYTE_W-1];
            shreg_n   = {shreg[BYTE_W-2:0], 1'b0};
            bit_cnt_n = CNT_W'(bit_cnt + CNT_W'(1));
            if (bit_cnt == CNT_W'(7)) begin
              bit_cnt_n = '0;
              addr_n    = addr_inc;
              shreg_n   = reg_rd(addr_inc, snap, {ctrl1_xl, ctrl2_g, ctrl4_c, ctrl9_xl});
            end
          end
        end
        WR: begin
          if (spc_rise) begin
            shreg_n   = rx_byte;
            bit_cnt_n = CNT_W'(bit_cnt + CNT_W'(1));
            if (bit_cnt == CNT_W'(7)) begin
              bit_cnt_n  = '0;
              wr_valid_n = 1'b1;
              wr_addr_n  = addr;
              wr_data_n  = rx_byte;
              addr_n     = addr_inc;
              case (addr)
                7'h10:   ctrl1_n = rx_byte;
                7'h11:   ctrl2_n = rx_byte;
                7'h13:   ctrl4_n = rx_byte;
                7'h18:   ctrl9_n = rx_byte;
                default: ;
              endcase
            end
          end
        end
        default: state_n = WAIT_CS_HIGH;
      endcase
    end
  end

endmodule
